status_reg: RTL and testbench

- Processor status register (P) stage directly downstream of the 6502 ALU.
- Captures each completed ALU result and updates the N, Z, C and V flags under a per-operation mask.
- Executes the explicit flag instructions (SEC/CLC/SEI/CLI/SED/CLD/CLV) and PLP loads.
- Drives the carry-in and decimal-mode inputs back into the ALU, and supplies the PHP/BRK push image.

---
 rtl/status_reg_pkg.sv | 52 +++++
 rtl/status_reg_if.sv | 30 +++
 rtl/status_reg_flag_calc.sv | 35 +++
 rtl/status_reg.sv | 92 +++++++++
 tb/tb_status_reg.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/status_reg_pkg.sv
// status_reg_pkg
//   Shared definitions for the 6502 status register (P) slice: data and
//   function-code widths, P bit positions, the ALU add function code,
//   explicit flag-op encodings, upd_mask bit positions and a helper that
//   forces the two hard-wired P bits.
package status_reg_pkg;

    localparam int REG_WIDTH = 8;
    localparam int OPP_WIDTH = 4;

    // P bit positions
    localparam int CARRY  = 0;
    localparam int ZERO   = 1;
    localparam int IRQ    = 2;
    localparam int DEC    = 3;
    localparam int BRK    = 4;
    localparam int UNUSED = 5;
    localparam int OVF    = 6;
    localparam int NEG    = 7;

    localparam logic [REG_WIDTH-1:0] RESET_P = 8'h24;

    // ALU function code for binary add (only code that affects V)
    localparam logic [OPP_WIDTH-1:0] SUM = 4'h3;

    // upd_mask bit positions, order {N,V,Z,C}
    localparam int MASK_C = 0;
    localparam int MASK_Z = 1;
    localparam int MASK_V = 2;
    localparam int MASK_N = 3;

    typedef enum logic [2:0] {
        FLAG_NOP = 3'd0,
        FLAG_CLC = 3'd1,
        FLAG_SEC = 3'd2,
        FLAG_CLI = 3'd3,
        FLAG_SEI = 3'd4,
        FLAG_CLD = 3'd5,
        FLAG_SED = 3'd6,
        FLAG_CLV = 3'd7
    } flag_op_e;

    // B is never stored (it only exists in pushed images) and bit 5 reads as 1.
    function automatic logic [REG_WIDTH-1:0] fix_bits(input logic [REG_WIDTH-1:0] p);
        logic [REG_WIDTH-1:0] r;
        r         = p;
        r[BRK]    = 1'b0;
        r[UNUSED] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/status_reg_if.sv
// status_reg_if
//   ALU <-> status register bundle.
//   master (ALU side): drives alu_dout, alu_a, alu_b, alu_carry, alu_func,
//                      alu_wout; receives carry_to_alu, dec_mode.
//   slave  (P side)  : the reverse.
interface status_reg_if
    import status_reg_pkg::*;
#(
    parameter int REG_W = REG_WIDTH,
    parameter int OPP_W = OPP_WIDTH
);
    logic [REG_W-1:0] alu_dout;
    logic [REG_W-1:0] alu_a;
    logic [REG_W-1:0] alu_b;
    logic             alu_carry;
    logic [OPP_W-1:0] alu_func;
    logic             alu_wout;
    logic             carry_to_alu;
    logic             dec_mode;

    modport master (
        output alu_dout, alu_a, alu_b, alu_carry, alu_func, alu_wout,
        input  carry_to_alu, dec_mode
    );

    modport slave (
        input  alu_dout, alu_a, alu_b, alu_carry, alu_func, alu_wout,
        output carry_to_alu, dec_mode
    );
endinterface

// File: rtl/status_reg_flag_calc.sv
// status_reg_flag_calc
//   Combinational N/Z/C/V candidates from one ALU result.
//   Ports: alu_dout, alu_a_msb, alu_b_hi ({b7,b6}), alu_carry, alu_func,
//          bit_mode -> n, z, c, v, v_valid (v only meaningful when set).
module status_reg_flag_calc
    import status_reg_pkg::*;
(
    input  logic [REG_WIDTH-1:0] alu_dout,
    input  logic                 alu_a_msb,
    input  logic [1:0]           alu_b_hi,
    input  logic                 alu_carry,
    input  logic [OPP_WIDTH-1:0] alu_func,
    input  logic                 bit_mode,
    output logic                 n,
    output logic                 z,
    output logic                 c,
    output logic                 v,
    output logic                 v_valid
);
    always_comb begin
        n       = bit_mode ? alu_b_hi[1] : alu_dout[REG_WIDTH-1];
        z       = (alu_dout == '0);
        c       = alu_carry;
        v       = 1'b0;
        v_valid = 1'b0;
        if (bit_mode) begin
            v       = alu_b_hi[0];
            v_valid = 1'b1;
        end else if (alu_func == SUM) begin
            // Signed overflow: operands share a sign the result does not.
            v       = (alu_a_msb == alu_b_hi[1]) && (alu_dout[REG_WIDTH-1] != alu_a_msb);
            v_valid = 1'b1;
        end
    end
endmodule

// File: rtl/status_reg.sv
// status_reg
//   6502 processor status register stage downstream of the ALU.
//   Ports: phi1 (clock), reset_n (sync, active-low), alu (ALU bundle, slave),
//          upd_mask {N,V,Z,C}, bit_mode, flag_op, p_load/p_din (PLP),
//          push_brk, p_out (current P), p_push (push image), upd_done.
module status_reg
    import status_reg_pkg::*;
(
    input  logic                 phi1,
    input  logic                 reset_n,
    status_reg_if.slave          alu,
    input  logic [3:0]           upd_mask,
    input  logic                 bit_mode,
    input  logic [2:0]           flag_op,
    input  logic                 p_load,
    input  logic [REG_WIDTH-1:0] p_din,
    input  logic                 push_brk,
    output logic [REG_WIDTH-1:0] p_out,
    output logic [REG_WIDTH-1:0] p_push,
    output logic                 upd_done
);
    logic [REG_WIDTH-1:0] p_q;
    logic [REG_WIDTH-1:0] p_next;
    logic                 wout_q;
    logic                 cap;
    logic                 n, z, c, v, v_valid;

    status_reg_flag_calc u_flag_calc (
        .alu_dout  (alu.alu_dout),
        .alu_a_msb (alu.alu_a[REG_WIDTH-1]),
        .alu_b_hi  (alu.alu_b[REG_WIDTH-1 -: 2]),
        .alu_carry (alu.alu_carry),
        .alu_func  (alu.alu_func),
        .bit_mode  (bit_mode),
        .n         (n),
        .z         (z),
        .c         (c),
        .v         (v),
        .v_valid   (v_valid)
    );

    // The ALU holds alu_wout high until its function changes, so only the
    // rising level is a new result.
    assign cap = alu.alu_wout && !wout_q;

    always_comb begin
        p_next = p_q;
        if (cap) begin
            if (upd_mask[MASK_N])            p_next[NEG]   = n;
            if (upd_mask[MASK_Z])            p_next[ZERO]  = z;
            if (upd_mask[MASK_C])            p_next[CARRY] = c;
            if (upd_mask[MASK_V] && v_valid) p_next[OVF]   = v;
        end
        // Applied after the capture so an explicit flag op wins on a shared bit.
        case (flag_op)
            FLAG_CLC: p_next[CARRY] = 1'b0;
            FLAG_SEC: p_next[CARRY] = 1'b1;
            FLAG_CLI: p_next[IRQ]   = 1'b0;
            FLAG_SEI: p_next[IRQ]   = 1'b1;
            FLAG_CLD: p_next[DEC]   = 1'b0;
            FLAG_SED: p_next[DEC]   = 1'b1;
            FLAG_CLV: p_next[OVF]   = 1'b0;
            default:  ;
        endcase
        if (p_load) p_next = p_din;
        p_next = fix_bits(p_next);
    end

    always_ff @(posedge phi1) begin
        if (!reset_n) begin
            p_q      <= RESET_P;
            wout_q   <= 1'b0;
            upd_done <= 1'b0;
        end else begin
            p_q      <= p_next;
            wout_q   <= alu.alu_wout;
            // Pulses even when PLP discards the captured flags.
            upd_done <= cap;
        end
    end

    always_comb begin
        p_push         = p_q;
        p_push[BRK]    = push_brk;
        p_push[UNUSED] = 1'b1;
    end

    assign p_out            = p_q;
    assign alu.carry_to_alu = p_q[CARRY];
    assign alu.dec_mode     = p_q[DEC];

endmodule

// File: tb/tb_status_reg.sv
module tb_status_reg;
    import status_reg_pkg::*;

    logic       phi1 = 1'b0;
    logic       reset_n;
    logic [3:0] upd_mask;
    logic       bit_mode;
    logic [2:0] flag_op;
    logic       p_load;
    logic [7:0] p_din;
    logic       push_brk;
    logic [7:0] p_out;
    logic [7:0] p_push;
    logic       upd_done;

    int n_vec = 0;
    int n_err = 0;

    status_reg_if alu ();

    status_reg dut (
        .phi1     (phi1),
        .reset_n  (reset_n),
        .alu      (alu.slave),
        .upd_mask (upd_mask),
        .bit_mode (bit_mode),
        .flag_op  (flag_op),
        .p_load   (p_load),
        .p_din    (p_din),
        .push_brk (push_brk),
        .p_out    (p_out),
        .p_push   (p_push),
        .upd_done (upd_done)
    );

    always #5 phi1 = ~phi1;

    task automatic tick();
        @(posedge phi1);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic alu_set(input logic wout, input logic [3:0] func, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] dout, input logic carry);
        alu.alu_wout  = wout;
        alu.alu_func  = func;
        alu.alu_a     = a;
        alu.alu_b     = b;
        alu.alu_dout  = dout;
        alu.alu_carry = carry;
    endtask

    initial begin
        reset_n  = 1'b0;
        upd_mask = 4'h0;
        bit_mode = 1'b0;
        flag_op  = FLAG_NOP;
        p_load   = 1'b0;
        p_din    = 8'h00;
        push_brk = 1'b0;
        alu_set(1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0);

        // Reset for two cycles
        tick();
        tick();
        check("reset_p", p_out, 8'h24);
        check("reset_done", {7'd0, upd_done}, 8'h00);
        check("reset_carry", {7'd0, alu.carry_to_alu}, 8'h00);
        check("reset_dec", {7'd0, alu.dec_mode}, 8'h00);
        check("reset_push", p_push, 8'h24);

        // Idle with X on ALU data: no capture, P holds
        reset_n = 1'b1;
        alu_set(1'b0, SUM, 8'hxx, 8'hxx, 8'hxx, 1'bx);
        upd_mask = 4'hF;
        tick();
        check("idle_x_p", p_out, 8'h24);

        // SUM overflow 0x50+0x50=0xA0
        alu_set(1'b1, SUM, 8'h50, 8'h50, 8'hA0, 1'b0);
        tick();
        check("ovf_p", p_out, 8'hE4);
        check("ovf_done", {7'd0, upd_done}, 8'h01);
        tick();  // wout stays high: no second update
        check("ovf_done_once", {7'd0, upd_done}, 8'h00);
        check("ovf_hold_p", p_out, 8'hE4);

        // Zero/carry with mask {Z,C}: N,V stay set
        alu_set(1'b0, SUM, 8'hxx, 8'hxx, 8'hxx, 1'bx);
        tick();
        alu_set(1'b1, SUM, 8'hFF, 8'h01, 8'h00, 1'b1);
        upd_mask = 4'h3;
        tick();
        check("zc_p", p_out, 8'hE7);
        check("zc_carry_to_alu", {7'd0, alu.carry_to_alu}, 8'h01);

        // CLC alone
        alu_set(1'b0, SUM, 8'hxx, 8'hxx, 8'hxx, 1'bx);
        flag_op = FLAG_CLC;
        tick();
        check("clc_p", p_out, 8'hE6);

        // SEC plus capture with mask {Z,C}, carry 0, nonzero result: SEC wins on C
        alu_set(1'b1, SUM, 8'h02, 8'h03, 8'h05, 1'b0);
        flag_op = FLAG_SEC;
        tick();
        check("conflict_p", p_out, 8'hE5);
        check("conflict_done", {7'd0, upd_done}, 8'h01);

        // PLP 0xDB with simultaneous capture: capture discarded, done still pulses
        alu_set(1'b0, SUM, 8'hxx, 8'hxx, 8'hxx, 1'bx);
        flag_op = FLAG_NOP;
        tick();
        alu_set(1'b1, SUM, 8'h00, 8'h00, 8'h00, 1'b1);
        upd_mask = 4'hF;
        p_load   = 1'b1;
        p_din    = 8'hDB;
        tick();
        check("plp_p", p_out, 8'hEB);
        check("plp_done", {7'd0, upd_done}, 8'h01);

        // Load 0x24, then push image with B
        alu_set(1'b0, SUM, 8'hxx, 8'hxx, 8'hxx, 1'bx);
        p_din = 8'h24;
        tick();
        p_load   = 1'b0;
        push_brk = 1'b1;
        #1;
        check("push_brk", p_push, 8'h34);
        check("push_p", p_out, 8'h24);

        // BIT with b=0xC0, mask {N,V,Z}, non-SUM function
        push_brk = 1'b0;
        bit_mode = 1'b1;
        alu_set(1'b1, 4'h1, 8'hxx, 8'hC0, 8'h00, 1'b0);
        upd_mask = 4'hE;
        tick();
        check("bit_p", p_out, 8'hE6);

        // Non-SUM function without bit_mode leaves V; SED/CLV via flag_op
        bit_mode = 1'b0;
        alu_set(1'b0, 4'h1, 8'hxx, 8'hxx, 8'hxx, 1'bx);
        flag_op = FLAG_SED;
        tick();
        check("sed_p", p_out, 8'hEE);
        check("sed_dec", {7'd0, alu.dec_mode}, 8'h01);
        alu_set(1'b1, 4'h1, 8'h7F, 8'h7F, 8'h01, 1'b0);
        upd_mask = 4'hF;
        flag_op  = FLAG_NOP;
        tick();
        check("nonsum_v_p", p_out, 8'h6C);
        alu_set(1'b0, 4'h1, 8'hxx, 8'hxx, 8'hxx, 1'bx);
        flag_op = FLAG_CLV;
        tick();
        check("clv_p", p_out, 8'h2C);
        flag_op = FLAG_CLI;
        tick();
        check("cli_p", p_out, 8'h28);
        flag_op = FLAG_SEI;
        tick();
        check("sei_p", p_out, 8'h2C);
        flag_op = FLAG_CLD;
        tick();
        check("cld_p", p_out, 8'h24);
        flag_op = FLAG_NOP;

        // Reset while a capture is presented: discarded
        reset_n = 1'b0;
        alu_set(1'b1, SUM, 8'h00, 8'h00, 8'h80, 1'b1);
        upd_mask = 4'h8;
        tick();
        check("rst_mid_p", p_out, 8'h24);
        check("rst_mid_done", {7'd0, upd_done}, 8'h00);

        // First cycle after reset with wout already high is a capture
        reset_n = 1'b1;
        tick();
        check("post_rst_p", p_out, 8'hA4);
        check("post_rst_done", {7'd0, upd_done}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
